// File: rtl/sa_axi4_burst_master.sv
// AXI4 INCR-burst master: moves 1..MAX_BURST_LEN words per command between local streams and memory.
// Optional RESP_CHECK_EN: sticky error on BRESP/RRESP != OKAY or RLAST/beat-count mismatch; W/R paths are zero-bubble pass-through.
module sa_axi4_burst_master #(
  parameter int                    ADDR_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] TARGET_BASE_ADDR = 32'h40000000,
  parameter int                    DATA_WIDTH       = 128,
  parameter int                    ID_WIDTH         = 1,
  parameter int                    IDX_WIDTH        = 9,
  parameter int                    MAX_BURST_LEN    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_mode,
  input  logic [IDX_WIDTH-1:0]    cmd_idx,
  input  logic [7:0]              cmd_len,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic                    st_valid,
  output logic                    st_ready,
  output logic [DATA_WIDTH-1:0]   ld_data,
  output logic                    ld_valid,
  input  logic                    ld_ready,
  output logic                    ld_last,
  output logic [ID_WIDTH-1:0]     m00_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [7:0]              m00_axi_awlen,
  output logic [2:0]              m00_axi_awsize,
  output logic [1:0]              m00_axi_awburst,
  output logic                    m00_axi_awlock,
  output logic [3:0]              m00_axi_awcache,
  output logic [2:0]              m00_axi_awprot,
  output logic [3:0]              m00_axi_awqos,
  output logic                    m00_axi_awvalid,
  input  logic                    m00_axi_awready,
  output logic [DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                    m00_axi_wlast,
  output logic                    m00_axi_wvalid,
  input  logic                    m00_axi_wready,
  input  logic [1:0]              m00_axi_bresp,
  input  logic                    m00_axi_bvalid,
  output logic                    m00_axi_bready,
  output logic [ID_WIDTH-1:0]     m00_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [7:0]              m00_axi_arlen,
  output logic [2:0]              m00_axi_arsize,
  output logic [1:0]              m00_axi_arburst,
  output logic                    m00_axi_arlock,
  output logic [3:0]              m00_axi_arcache,
  output logic [2:0]              m00_axi_arprot,
  output logic [3:0]              m00_axi_arqos,
  output logic                    m00_axi_arvalid,
  input  logic                    m00_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]              m00_axi_rresp,
  input  logic                    m00_axi_rlast,
  input  logic                    m00_axi_rvalid,
  output logic                    m00_axi_rready
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  localparam int         SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam logic [7:0] LEN_CAP   = 8'(MAX_BURST_LEN - 1);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]             last_q, last_d;
  logic [7:0]             beat_q, beat_d;
  logic                   awvalid_q, awvalid_d;
  logic                   arvalid_q, arvalid_d;
  logic                   bready_q, bready_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   error_q, error_d;

  logic                   accept;
  logic                   w_hs;
  logic                   r_hs;
  logic                   final_beat;
  logic [ADDR_WIDTH-1:0]  cmd_addr;

  assign accept     = (state_q == S_IDLE) && cmd_valid;
  assign w_hs       = (state_q == S_W) && st_valid && m00_axi_wready;
  assign r_hs       = (state_q == S_R) && m00_axi_rvalid && ld_ready;
  assign final_beat = (beat_q == last_q);
  assign cmd_addr   = TARGET_BASE_ADDR + (ADDR_WIDTH'(cmd_idx) << SIZE_LOG2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          last_d = (cmd_len > LEN_CAP) ? LEN_CAP : cmd_len;
          beat_d = '0;
          case (cmd_mode)
            2'd1:    state_d = S_AR;
            2'd2:    state_d = S_AW;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_AW: if (m00_axi_awready) state_d = S_W;
      S_W: begin
        if (w_hs) begin
          if (final_beat) state_d = S_B;
          else            beat_d  = beat_q + 8'd1;
        end
      end
      S_B:  if (m00_axi_bvalid) state_d = S_DONE;
      S_AR: if (m00_axi_arready) state_d = S_R;
      S_R: begin
        if (r_hs) begin
          beat_d = beat_q + 8'd1;
          if (m00_axi_rlast) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Control outputs are registered copies of the next-state decode.
    awvalid_d   = (state_d == S_AW);
    arvalid_d   = (state_d == S_AR);
    bready_d    = (state_d == S_B);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);

`ifdef RESP_CHECK_EN
    error_d = error_q;
    if (accept)
      error_d = 1'b0;
    else if ((state_q == S_B) && m00_axi_bvalid && (m00_axi_bresp != 2'b00))
      error_d = 1'b1;
    else if (r_hs && ((m00_axi_rresp != 2'b00) || (m00_axi_rlast != final_beat)))
      error_d = 1'b1;
`else
    error_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      beat_q      <= '0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      awvalid_q   <= awvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      error_q     <= error_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

  assign m00_axi_awid    = '0;
  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_awlen   = last_q;
  assign m00_axi_awsize  = 3'(SIZE_LOG2);
  assign m00_axi_awburst = 2'b01;
  assign m00_axi_awlock  = 1'b0;
  assign m00_axi_awcache = 4'b0011;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awqos   = 4'b0000;
  assign m00_axi_awvalid = awvalid_q;

  assign m00_axi_wdata  = st_data;
  assign m00_axi_wstrb  = '1;
  assign m00_axi_wvalid = (state_q == S_W) && st_valid;
  assign m00_axi_wlast  = (state_q == S_W) && final_beat;
  assign st_ready       = (state_q == S_W) && m00_axi_wready;
  assign m00_axi_bready = bready_q;

  assign m00_axi_arid    = '0;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_arlen   = last_q;
  assign m00_axi_arsize  = 3'(SIZE_LOG2);
  assign m00_axi_arburst = 2'b01;
  assign m00_axi_arlock  = 1'b0;
  assign m00_axi_arcache = 4'b0011;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arqos   = 4'b0000;
  assign m00_axi_arvalid = arvalid_q;

  assign m00_axi_rready = (state_q == S_R) && ld_ready;
  assign ld_valid       = (state_q == S_R) && m00_axi_rvalid;
  assign ld_data        = m00_axi_rdata;
  assign ld_last        = (state_q == S_R) && m00_axi_rlast;

endmodule

// File: tb/tb_sa_axi4_burst_master.sv
// Bench for sa_axi4_burst_master: randomized streams and AXI slave timing checked against a word-level memory model.
module tb_sa_axi4_burst_master;
  localparam logic [31:0] BASE = 32'h40000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, cmd_valid, cmd_ready, busy, done, error;
  logic [1:0] cmd_mode;
  logic [8:0] cmd_idx;
  logic [7:0] cmd_len;
  logic [127:0] st_data, ld_data;
  logic st_valid, st_ready, ld_valid, ld_ready, ld_last;
  logic [0:0] awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awvalid, awready, arvalid, arready;
  logic [3:0] awcache, arcache, awqos, arqos;
  logic [127:0] wdata, rdata;
  logic [15:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  sa_axi4_burst_master #(
    .ADDR_WIDTH(32), .TARGET_BASE_ADDR(BASE), .DATA_WIDTH(128),
    .ID_WIDTH(1), .IDX_WIDTH(9), .MAX_BURST_LEN(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_idx(cmd_idx), .cmd_len(cmd_len),
    .busy(busy), .done(done), .error(error),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_last(ld_last),
    .m00_axi_awid(awid), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen), .m00_axi_awsize(awsize),
    .m00_axi_awburst(awburst), .m00_axi_awlock(awlock), .m00_axi_awcache(awcache), .m00_axi_awprot(awprot),
    .m00_axi_awqos(awqos), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast), .m00_axi_wvalid(wvalid),
    .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_arid(arid), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen), .m00_axi_arsize(arsize),
    .m00_axi_arburst(arburst), .m00_axi_arlock(arlock), .m00_axi_arcache(arcache), .m00_axi_arprot(arprot),
    .m00_axi_arqos(arqos), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave memory (what the bus sees) and reference model memory (what the bench intends).
  logic [127:0] mem [0:1023];
  logic [127:0] ref_mem [int];
  logic [127:0] src_q [$];

  int st_valid_pct, wready_pct, aw_delay, ar_delay, r_gap, ld_mode, early_rlast, abort_beat;
  logic [1:0] bresp_cfg, rresp_cfg;

  logic [31:0]  o_awaddr, o_araddr;
  logic [7:0]   o_awlen, o_arlen;
  int           o_aw_cnt, o_ar_cnt, o_b_cnt, o_done_cyc, o_done_cnt;
  logic [127:0] o_w [$];
  logic [127:0] o_ld [$];
  int           o_wlast [$];
  int           o_ldlast [$];
  bit           o_timeout, o_axi_act, o_pass_bad, o_b_before_done;

  function automatic logic [127:0] ref_rd(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 128'd0;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 4) % 1024;
  endfunction

  task automatic cfg_default();
    st_valid_pct = 100; wready_pct = 100; aw_delay = 0; ar_delay = 0; r_gap = 0;
    ld_mode = 0; early_rlast = -1; abort_beat = -1; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_mode = 0; cmd_idx = 0; cmd_len = 0;
    st_valid = 0; st_data = '0; ld_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
  endtask

  task automatic fill_src_random();
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  // Issues one command and plays AXI slave + stream endpoints until done (or abort/timeout).
  task automatic run_cmd(input logic [1:0] mode, input int idx, input int len);
    int n, aw_wait, ar_wait, gap, rsent;
    bit tog;
    logic [127:0] rq [$];
    o_w.delete(); o_ld.delete(); o_wlast.delete(); o_ldlast.delete();
    o_aw_cnt = 0; o_ar_cnt = 0; o_b_cnt = 0; o_done_cyc = -1; o_done_cnt = 0;
    o_timeout = 0; o_axi_act = 0; o_pass_bad = 0; o_b_before_done = 0;
    aw_wait = aw_delay; ar_wait = ar_delay; gap = 0; rsent = 0; tog = 0; n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_mode = mode; cmd_idx = 9'(idx); cmd_len = 8'(len);
    #1;
    while (!cmd_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!cmd_ready) begin o_timeout = 1; cmd_valid = 0; return; end
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      cmd_valid = 0; n++;
      awready = awvalid && (aw_wait == 0);
      if (awvalid && aw_wait > 0) aw_wait--;
      arready = arvalid && (ar_wait == 0);
      if (arvalid && ar_wait > 0) ar_wait--;
      st_valid = ($urandom_range(99) < st_valid_pct);
      st_data  = (o_w.size() < src_q.size()) ? src_q[o_w.size()] : 128'd0;
      wready   = ($urandom_range(99) < wready_pct);
      bvalid   = (o_aw_cnt == 1) && (o_w.size() == int'(o_awlen) + 1) && (o_b_cnt == 0);
      bresp    = bresp_cfg;
      rresp    = rresp_cfg;
      if (rq.size() > 0 && gap == 0) begin
        rvalid = 1; rdata = rq[0];
        rlast  = (rq.size() == 1) || (early_rlast >= 0 && rsent == early_rlast);
      end else begin
        rvalid = 0; rlast = 0;
        if (gap > 0) gap--;
      end
      case (ld_mode)
        0:       ld_ready = 1;
        1:       begin tog = ~tog; ld_ready = tog; end
        default: ld_ready = 1'($urandom_range(1));
      endcase
      #1;
      if ((st_ready && !wready) || (wvalid && !st_valid) || (st_valid && wready && wvalid && !st_ready) ||
          (wvalid && wdata !== st_data)) o_pass_bad = 1;
      if ((ld_valid && !rvalid) || (rready && !ld_ready) || (ld_valid && ld_ready && !rready) ||
          (ld_valid && ld_data !== rdata) || (ld_last && !rlast)) o_pass_bad = 1;
      if (awvalid || arvalid || wvalid || bready || rready || ld_valid) o_axi_act = 1;
      if (awvalid && awready) begin o_aw_cnt++; o_awaddr = awaddr; o_awlen = awlen; end
      if (wvalid && wready) begin
        o_w.push_back(wdata);
        if (wlast) o_wlast.push_back(o_w.size() - 1);
      end
      if (bvalid && bready) begin
        o_b_cnt++;
        for (int i = 0; i < o_w.size(); i++) mem[(word_of(o_awaddr) + i) % 1024] = o_w[i];
      end
      if (arvalid && arready) begin
        o_ar_cnt++; o_araddr = araddr; o_arlen = arlen;
        for (int i = 0; i <= int'(arlen); i++) rq.push_back(mem[(word_of(araddr) + i) % 1024]);
      end
      if (rvalid && rready) begin
        o_ld.push_back(ld_data);
        if (ld_last) o_ldlast.push_back(o_ld.size() - 1);
        void'(rq.pop_front());
        rsent++; gap = r_gap;
        if (rlast) rq.delete();
      end
      if (done) begin
        o_done_cnt++;
        if (o_done_cyc < 0) begin o_done_cyc = n; o_b_before_done = (o_b_cnt > 0); end
      end
      if (o_done_cnt > 0) break;
      if (abort_beat >= 0 && o_w.size() == abort_beat) break;
    end
    if (n >= 3000) o_timeout = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; st_valid = 1; wready = 1; rvalid = 1; rlast = 1; ld_ready = 1; bvalid = 1; awready = 1; arready = 1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({awvalid, arvalid, wvalid, st_ready, bready, rready, ld_valid, ld_last, done, busy, error} !== 11'b0) begin
      n_fail++; $display("FAIL reset_outputs got %b want 0", {awvalid, arvalid, wvalid, st_ready, bready, rready, ld_valid, ld_last, done, busy, error});
    end
    @(negedge clk); reset = 0;
    @(negedge clk); #1;
    n_tests++;
    if ({cmd_ready, busy, awvalid, arvalid, wvalid, st_ready, bready, rready, ld_valid} !== 9'b100000000) begin
      n_fail++; $display("FAIL idle_after_reset got %b want 100000000", {cmd_ready, busy, awvalid, arvalid, wvalid, st_ready, bready, rready, ld_valid});
    end
    idle_inputs();
  endtask

  task automatic test_single_store();
    cfg_default();
    src_q.delete(); src_q.push_back(128'h19);
    run_cmd(2'd2, 5, 0);
    n_tests++; if (o_awaddr !== 32'h40000050) begin n_fail++; $display("FAIL single_awaddr got %h want 40000050", o_awaddr); end
    n_tests++; if (o_awlen !== 8'd0) begin n_fail++; $display("FAIL single_awlen got %0d want 0", o_awlen); end
    n_tests++;
    if ({awid, awsize, awburst, awlock, awcache, awprot, awqos, arsize, arburst, arcache, wstrb} !== {1'b0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 3'd4, 2'b01, 4'b0011, 16'hFFFF}) begin
      n_fail++; $display("FAIL static_fields got %h", {awid, awsize, awburst, awlock, awcache, awprot, awqos, arsize, arburst, arcache, wstrb});
    end
    n_tests++;
    if (o_w.size() !== 1 || o_w[0] !== 128'h19 || o_wlast.size() !== 1 || o_wlast[0] !== 0) begin
      n_fail++; $display("FAIL single_wbeat got n=%0d d=%h lasts=%0d want 1 beat 19 with wlast", o_w.size(), o_w[0], o_wlast.size());
    end
    n_tests++;
    if (o_timeout || o_done_cnt !== 1 || !o_b_before_done) begin
      n_fail++; $display("FAIL single_done got to=%0d done=%0d after_b=%0d want 0 1 1", o_timeout, o_done_cnt, o_b_before_done);
    end
    ref_mem[5] = 128'h19;
    @(negedge clk); #1;
    n_tests++;
    if ({done, cmd_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL done_one_cycle got %b want 010", {done, cmd_ready, busy}); end
    idle_inputs();
  endtask

  task automatic test_burst_store_load();
    int bad;
    cfg_default();
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(128'(i * i));
    run_cmd(2'd2, 0, 15);
    bad = 0;
    for (int i = 0; i < 16; i++) if (o_w[i] !== 128'(i * i)) bad++;
    n_tests++;
    if (o_w.size() !== 16 || bad !== 0 || o_awlen !== 8'd15) begin
      n_fail++; $display("FAIL burst_store got beats=%0d bad=%0d awlen=%0d want 16 0 15", o_w.size(), bad, o_awlen);
    end
    n_tests++;
    if (o_wlast.size() !== 1 || o_wlast[0] !== 15) begin
      n_fail++; $display("FAIL burst_wlast got count=%0d pos=%0d want 1 at 15", o_wlast.size(), o_wlast[0]);
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 128'(i * i);
    idle_inputs();
    run_cmd(2'd1, 0, 15);
    bad = 0;
    for (int i = 0; i < 16; i++) if (o_ld[i] !== ref_rd(i)) bad++;
    n_tests++;
    if (o_ld.size() !== 16 || bad !== 0 || o_araddr !== BASE || o_arlen !== 8'd15) begin
      n_fail++; $display("FAIL burst_load got beats=%0d bad=%0d araddr=%h arlen=%0d", o_ld.size(), bad, o_araddr, o_arlen);
    end
    n_tests++;
    if (o_ldlast.size() !== 1 || o_ldlast[0] !== 15 || o_pass_bad || o_timeout) begin
      n_fail++; $display("FAIL burst_ld_last got count=%0d pos=%0d pass_bad=%0d to=%0d", o_ldlast.size(), o_ldlast[0], o_pass_bad, o_timeout);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int bad;
    cfg_default();
    fill_src_random();
    st_valid_pct = 60; wready_pct = 50;
    run_cmd(2'd2, 100, 15);
    bad = 0;
    for (int i = 0; i < 16; i++) if (o_w[i] !== src_q[i]) bad++;
    n_tests++;
    if (o_w.size() !== 16 || bad !== 0 || o_awaddr !== 32'h40000640 || o_pass_bad) begin
      n_fail++; $display("FAIL bp_store got beats=%0d bad=%0d addr=%h pass_bad=%0d", o_w.size(), bad, o_awaddr, o_pass_bad);
    end
    for (int i = 0; i < 16; i++) ref_mem[100 + i] = src_q[i];
    idle_inputs();
    cfg_default();
    ld_mode = 1; ar_delay = 3; r_gap = 3;
    run_cmd(2'd1, 100, 15);
    bad = 0;
    for (int i = 0; i < 16; i++) if (o_ld[i] !== ref_rd(100 + i)) bad++;
    n_tests++;
    if (o_ld.size() !== 16 || bad !== 0 || o_ar_cnt !== 1 || o_pass_bad || o_timeout) begin
      n_fail++; $display("FAIL bp_load got beats=%0d bad=%0d ar=%0d pass_bad=%0d to=%0d", o_ld.size(), bad, o_ar_cnt, o_pass_bad, o_timeout);
    end
    idle_inputs();
  endtask

  task automatic test_len_and_modes();
    int idx, len, beats, bad;
    logic [1:0] mode;
    logic [31:0] exp_addr;
    cfg_default();
    fill_src_random();
    run_cmd(2'd2, 2, 40);
    n_tests++;
    if (o_awlen !== 8'd15 || o_w.size() !== 16) begin
      n_fail++; $display("FAIL len_clamp got awlen=%0d beats=%0d want 15 16", o_awlen, o_w.size());
    end
    for (int i = 0; i < 16; i++) ref_mem[2 + i] = src_q[i];
    for (int m = 0; m < 4; m += 3) begin
      idle_inputs();
      run_cmd(2'(m), 7, 3);
      n_tests++;
      if (o_done_cyc !== 1 || o_axi_act || o_aw_cnt + o_ar_cnt !== 0) begin
        n_fail++; $display("FAIL idle_mode%0d got done_cyc=%0d axi_act=%0d want 1 0", m, o_done_cyc, o_axi_act);
      end
    end
    for (int it = 0; it < 8; it++) begin
      idle_inputs();
      cfg_default();
      fill_src_random();
      mode = ($urandom_range(1) == 1) ? 2'd2 : 2'd1;
      idx = $urandom_range(400); len = $urandom_range(40);
      st_valid_pct = $urandom_range(100, 40); wready_pct = $urandom_range(100, 40);
      ld_mode = $urandom_range(2); aw_delay = $urandom_range(3); ar_delay = $urandom_range(3); r_gap = $urandom_range(2);
      beats = ((len > 15) ? 15 : len) + 1;
      exp_addr = BASE + 32'(idx) * 32'd16;
      run_cmd(mode, idx, len);
      bad = 0;
      if (mode == 2'd2) begin
        for (int i = 0; i < beats; i++) if (o_w[i] !== src_q[i]) bad++;
        n_tests++;
        if (o_awaddr !== exp_addr || o_w.size() !== beats || bad !== 0 || o_timeout) begin
          n_fail++; $display("FAIL rand_store it%0d got addr=%h beats=%0d bad=%0d want %h %0d 0", it, o_awaddr, o_w.size(), bad, exp_addr, beats);
        end
        for (int i = 0; i < beats; i++) ref_mem[idx + i] = src_q[i];
      end else begin
        for (int i = 0; i < beats; i++) if (o_ld[i] !== ref_rd(idx + i)) bad++;
        n_tests++;
        if (o_araddr !== exp_addr || o_ld.size() !== beats || bad !== 0 || o_timeout) begin
          n_fail++; $display("FAIL rand_load it%0d got addr=%h beats=%0d bad=%0d want %h %0d 0", it, o_araddr, o_ld.size(), bad, exp_addr, beats);
        end
      end
      n_tests++;
      if (o_pass_bad) begin n_fail++; $display("FAIL rand_passthru it%0d got 1 want 0", it); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midburst();
    int bad;
    cfg_default();
    fill_src_random();
    abort_beat = 7;
    run_cmd(2'd2, 20, 15);
    reset = 1; st_valid = 1; wready = 1;
    @(negedge clk); reset = 0; #1;
    n_tests++;
    if ({cmd_ready, busy, done, awvalid, wvalid, st_ready, bready, arvalid, rready} !== 9'b100000000) begin
      n_fail++; $display("FAIL abort_state got %b want 100000000", {cmd_ready, busy, done, awvalid, wvalid, st_ready, bready, arvalid, rready});
    end
    idle_inputs();
    cfg_default();
    run_cmd(2'd1, 0, 3);
    bad = 0;
    for (int i = 0; i < 4; i++) if (o_ld[i] !== ref_rd(i)) bad++;
    n_tests++;
    if (o_ld.size() !== 4 || bad !== 0 || o_done_cnt !== 1) begin
      n_fail++; $display("FAIL after_abort got beats=%0d bad=%0d done=%0d want 4 0 1", o_ld.size(), bad, o_done_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_resp_error();
    cfg_default();
    fill_src_random();
    bresp_cfg = 2'b10;
    run_cmd(2'd2, 300, 3);
`ifdef RESP_CHECK_EN
    n_tests++;
    if (error !== 1'b1 || o_done_cnt !== 1) begin n_fail++; $display("FAIL bresp_err got err=%b done=%0d want 1 1", error, o_done_cnt); end
    idle_inputs();
    @(negedge clk); #1;
    n_tests++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", error); end
    cfg_default();
    run_cmd(2'd0, 0, 0);
    n_tests++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", error); end
    idle_inputs();
    rresp_cfg = 2'b11;
    run_cmd(2'd1, 300, 3);
    n_tests++;
    if (error !== 1'b1 || o_ld.size() !== 4) begin n_fail++; $display("FAIL rresp_err got err=%b beats=%0d want 1 4", error, o_ld.size()); end
    idle_inputs();
    cfg_default();
    run_cmd(2'd0, 0, 0);
    idle_inputs();
    early_rlast = 3;
    run_cmd(2'd1, 300, 7);
    n_tests++;
    if (error !== 1'b1 || o_ld.size() !== 4 || o_done_cnt !== 1) begin
      n_fail++; $display("FAIL rlast_err got err=%b beats=%0d done=%0d want 1 4 1", error, o_ld.size(), o_done_cnt);
    end
`else
    n_tests++;
    if (error !== 1'b0 || o_done_cnt !== 1) begin n_fail++; $display("FAIL bresp_ignored got err=%b done=%0d want 0 1", error, o_done_cnt); end
    idle_inputs();
    early_rlast = 3; rresp_cfg = 2'b10;
    run_cmd(2'd1, 300, 7);
    n_tests++;
    if (error !== 1'b0 || o_ld.size() !== 4 || o_done_cnt !== 1) begin
      n_fail++; $display("FAIL rresp_ignored got err=%b beats=%0d done=%0d want 0 4 1", error, o_ld.size(), o_done_cnt);
    end
`endif
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    cfg_default();
    idle_inputs();
    reset = 1;
    test_reset();
    test_single_store();
    test_burst_store_load();
    test_backpressure();
    test_len_and_modes();
    test_reset_midburst();
    test_resp_error();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
